wb_regfile: RTL and testbench
=============================

WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have ports: clk  in  1  single clock; all register-file writes occur on its rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-high; clears all registers immediately.
REQ-003 SHALL have ports: RegWrite_W  in  1  writeback enable from the MEM/WB stage.
REQ-004 SHALL have ports: MemtoReg_W  in  2  source select: 00 ALUOut_W, 01 extended load data, 10 HL_W, 11 ALUOut_W.
REQ-005 SHALL have ports: ReadData_W  in  32  raw data-memory word.
REQ-006 SHALL have ports: ALUOut_W  in  32  ALU result; bits [1:0] are the load byte offset.
REQ-007 SHALL have ports: WriteReg_W  in  5  destination register number.
REQ-008 SHALL have ports: npc_W  in  32  PC+4 of the writing instruction.
REQ-009 SHALL have ports: Jal_W  in  1  link write; overrides MemtoReg_W.
REQ-010 SHALL have ports: ExtDM_W  in  3  load extension: 000 word, 001 lbu, 010 lb, 011 lhu, 100 lh, others word.
REQ-011 SHALL have ports: HL_W  in  32  HI/LO move data.
REQ-012 SHALL have ports: A1, A2  in  5 each  read addresses from the decode stage.
REQ-013 SHALL have ports: RD1, RD2  out  32 each  read data.
REQ-014 SHALL have ports: WD_W  out  32  final writeback value, for forwarding into EX/MEM.
REQ-015 SHALL have ports: WrCount  out  16  count of committed register writes.

Function
REQ-016 Byte select SHALL be little-endian: offset 0 -> ReadData_W[7:0], 1 -> [15:8], 2 -> [23:16], 3 -> [31:24].
REQ-017 Halfword select SHALL use ALUOut_W[1]: 0 -> [15:0], 1 -> [31:16]; ALUOut_W[0] is ignored.
REQ-018 lb and lh SHALL sign-extend to 32 bits; lbu and lhu SHALL zero-extend; word loads SHALL pass ReadData_W unchanged.
REQ-019 WD_W SHALL be npc_W+4 (mod 2^32) when Jal_W=1; otherwise it SHALL be selected per MemtoReg_W; it is purely combinational.
REQ-020 On a rising clk edge with RegWrite_W=1 and WriteReg_W!=0, register[WriteReg_W] SHALL take WD_W, and WrCount SHALL increment by 1.
REQ-021 A write to register 0 SHALL be discarded and SHALL NOT increment WrCount; register 0 SHALL always read as 0.
REQ-022 WrCount SHALL wrap from 0xFFFF to 0x0000.
REQ-023 RD1 and RD2 SHALL be combinational reads of register[A1] and register[A2]; A1==A2 SHALL return identical data on both ports.
REQ-024 With RegWrite_W=0, no register and no counter SHALL change.

Reset
REQ-025 reset=1 SHALL force registers 1..31 and WrCount to 0 asynchronously, without waiting for a clock edge.
REQ-026 While reset=1, rising clk edges SHALL perform no writes, even with RegWrite_W=1.
REQ-027 After reset deasserts, the first write SHALL occur on the next rising edge on which RegWrite_W=1.
REQ-028 reset asserted in the same cycle as a pending write SHALL drop that write.

Configuration
REQ-029 Macro WB_REGFILE_BYPASS_EN, when defined, SHALL add write-through bypass: if RegWrite_W=1, WriteReg_W!=0, WriteReg_W==A1 and reset=0, then RD1=WD_W in the same cycle; RD2 SHALL behave the same way with A2.
REQ-030 When WB_REGFILE_BYPASS_EN is undefined, RD1 and RD2 SHALL return stored contents only, and the new value SHALL become visible the cycle after the write.

Verification
REQ-031 Reset, then a write with RegWrite=1, WriteReg=5, MemtoReg=00, ALUOut=0x12345678 -> next cycle A1=5 gives RD1=0x12345678 and WrCount=1.
REQ-032 ReadData=0x80FF7F01, MemtoReg=01, ALUOut[1:0]=1, ExtDM=010 -> WD_W=0x0000007F. With ExtDM=011 and ALUOut[1:0]=2 -> WD_W=0x000080FF. With ExtDM=100 and ALUOut[1:0]=2 -> WD_W=0xFFFF80FF.
REQ-033 Jal=1, npc=0x00003004, WriteReg=31, MemtoReg=01 -> register 31=0x00003008.
REQ-034 A write of 0xDEADBEEF to register 0 -> RD1 reads 0 with A1=0, and WrCount is unchanged.
REQ-035 Same-cycle write of 0xA5A5A5A5 to register 7 with A2=7 -> RD2=0xA5A5A5A5 that cycle with the macro defined; without the macro, RD2 shows the old value and the new value appears the next cycle.
REQ-036 Load 0xFFFF into WrCount, perform one more write -> WrCount=0; then assert reset mid-cycle -> all RD outputs read 0 before the next clock edge.

Source files
------------

// File: rtl/wb_regfile.sv
// wb_regfile: MIPS-style writeback stage and 32 x 32-bit register file.
//   Builds the writeback value (ALU result, extended load data, HI/LO data
//   or the link address), commits it on the rising edge of clk, and counts
//   the register writes that were committed.
// Ports:
//   clk, reset        clock; asynchronous active-high reset
//   RegWrite_W        writeback enable
//   MemtoReg_W        source select: 00/11 ALUOut_W, 01 load data, 10 HL_W
//   ReadData_W        raw data-memory word
//   ALUOut_W          ALU result; [1:0] is the load byte offset
//   WriteReg_W        destination register number
//   npc_W, Jal_W      PC+4 of the writing instruction; link-write select
//   ExtDM_W           load extension: 000 word, 001 lbu, 010 lb, 011 lhu, 100 lh
//   HL_W              HI/LO move data
//   A1, A2 / RD1, RD2 combinational read ports
//   WD_W              combinational writeback value, for forwarding
//   WrCount           registered count of committed writes (wraps at 16 bits)
// Optional feature:
//   WB_REGFILE_BYPASS_EN  when defined, a write in flight is forwarded to RD1/RD2
//                         in the same cycle as the write.
module wb_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWrite_W,
    input  logic [1:0]  MemtoReg_W,
    input  logic [31:0] ReadData_W,
    input  logic [31:0] ALUOut_W,
    input  logic [4:0]  WriteReg_W,
    input  logic [31:0] npc_W,
    input  logic        Jal_W,
    input  logic [2:0]  ExtDM_W,
    input  logic [31:0] HL_W,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    output logic [31:0] RD1,
    output logic [31:0] RD2,
    output logic [31:0] WD_W,
    output logic [15:0] WrCount
);

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned CNT_W    = 16;
    localparam int unsigned NUM_REGS = 32;

    localparam logic [2:0] EXT_LBU = 3'b001;
    localparam logic [2:0] EXT_LB  = 3'b010;
    localparam logic [2:0] EXT_LHU = 3'b011;
    localparam logic [2:0] EXT_LH  = 3'b100;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [CNT_W-1:0]  wr_count;
    logic [7:0]        load_byte;
    logic [15:0]       load_half;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] wd;
    logic              write_en;
    logic [DATA_W-1:0] rd1_stored;
    logic [DATA_W-1:0] rd2_stored;

    // Little-endian byte and halfword lane selection
    always_comb begin
        load_byte = ReadData_W[7:0];
        case (ALUOut_W[1:0])
            2'd0:    load_byte = ReadData_W[7:0];
            2'd1:    load_byte = ReadData_W[15:8];
            2'd2:    load_byte = ReadData_W[23:16];
            default: load_byte = ReadData_W[31:24];
        endcase
        load_half = ALUOut_W[1] ? ReadData_W[31:16] : ReadData_W[15:0];
    end

    // Load extension; unlisted encodings fall back to a plain word load
    always_comb begin
        load_data = ReadData_W;
        case (ExtDM_W)
            EXT_LBU: load_data = {24'h000000, load_byte};
            EXT_LB:  load_data = {{24{load_byte[7]}}, load_byte};
            EXT_LHU: load_data = {16'h0000, load_half};
            EXT_LH:  load_data = {{16{load_half[15]}}, load_half};
            default: load_data = ReadData_W;
        endcase
    end

    // Writeback source select; a link write takes priority over MemtoReg_W
    always_comb begin
        wd = ALUOut_W;
        if (Jal_W) begin
            wd = npc_W + DATA_W'(4);
        end else begin
            case (MemtoReg_W)
                2'b01:   wd = load_data;
                2'b10:   wd = HL_W;
                default: wd = ALUOut_W;
            endcase
        end
    end

    assign WD_W     = wd;
    assign write_en = RegWrite_W && (WriteReg_W != ADDR_W'(0));

    // Register array and write counter; register 0 is never written
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs[i] <= '0;
            end
            wr_count <= '0;
        end else if (write_en) begin
            regs[WriteReg_W] <= wd;
            wr_count         <= wr_count + CNT_W'(1);
        end
    end

    assign WrCount = wr_count;

    // Register 0 reads as zero regardless of array contents
    always_comb begin
        rd1_stored = (A1 == ADDR_W'(0)) ? '0 : regs[A1];
        rd2_stored = (A2 == ADDR_W'(0)) ? '0 : regs[A2];
    end

`ifdef WB_REGFILE_BYPASS_EN
    // Write-through: a matching write in flight is visible this cycle
    always_comb begin
        RD1 = rd1_stored;
        RD2 = rd2_stored;
        if (write_en && !reset && (WriteReg_W == A1)) begin
            RD1 = wd;
        end
        if (write_en && !reset && (WriteReg_W == A2)) begin
            RD2 = wd;
        end
    end
`else
    // Stored contents only; a write becomes visible the following cycle
    always_comb begin
        RD1 = rd1_stored;
        RD2 = rd2_stored;
    end
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile.
module tb_wb_regfile;

    logic        clk;
    logic        reset;
    logic        RegWrite_W;
    logic [1:0]  MemtoReg_W;
    logic [31:0] ReadData_W;
    logic [31:0] ALUOut_W;
    logic [4:0]  WriteReg_W;
    logic [31:0] npc_W;
    logic        Jal_W;
    logic [2:0]  ExtDM_W;
    logic [31:0] HL_W;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] RD1;
    logic [31:0] RD2;
    logic [31:0] WD_W;
    logic [15:0] WrCount;

    int errors = 0;
    int checks = 0;

    wb_regfile dut (
        .clk        (clk),
        .reset      (reset),
        .RegWrite_W (RegWrite_W),
        .MemtoReg_W (MemtoReg_W),
        .ReadData_W (ReadData_W),
        .ALUOut_W   (ALUOut_W),
        .WriteReg_W (WriteReg_W),
        .npc_W      (npc_W),
        .Jal_W      (Jal_W),
        .ExtDM_W    (ExtDM_W),
        .HL_W       (HL_W),
        .A1         (A1),
        .A2         (A2),
        .RD1        (RD1),
        .RD2        (RD2),
        .WD_W       (WD_W),
        .WrCount    (WrCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; RegWrite_W = 1'b0; MemtoReg_W = 2'b00; ReadData_W = '0;
        ALUOut_W = '0; WriteReg_W = '0; npc_W = '0; Jal_W = 1'b0; ExtDM_W = '0;
        HL_W = '0; A1 = 5'd5; A2 = 5'd31;
        tick(); tick();
        checks++;
        if (WrCount !== 16'h0000) begin
            errors++; $display("FAIL reset_wrcount got=%h exp=0000", WrCount);
        end
        checks++;
        if (RD1 !== 32'h0) begin
            errors++; $display("FAIL reset_rd1 got=%h exp=00000000", RD1);
        end
        checks++;
        if (RD2 !== 32'h0) begin
            errors++; $display("FAIL reset_rd2 got=%h exp=00000000", RD2);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_alu_write();
        RegWrite_W = 1'b1; WriteReg_W = 5'd5; MemtoReg_W = 2'b00; ALUOut_W = 32'h12345678;
        #1;
        checks++;
        if (WD_W !== 32'h12345678) begin
            errors++; $display("FAIL alu_wd got=%h exp=12345678", WD_W);
        end
        tick();
        RegWrite_W = 1'b0; A1 = 5'd5;
        #1;
        checks++;
        if (RD1 !== 32'h12345678) begin
            errors++; $display("FAIL alu_rd1 got=%h exp=12345678", RD1);
        end
        checks++;
        if (WrCount !== 16'd1) begin
            errors++; $display("FAIL alu_wrcount got=%0d exp=1", WrCount);
        end
    endtask

    task automatic test_load_ext();
        logic [1:0]  offs [10] = '{2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0, 2'd3, 2'd1, 2'd0};
        logic [2:0]  exts [10] = '{3'd2, 3'd3, 3'd4, 3'd1, 3'd2, 3'd0, 3'd4, 3'd4, 3'd7, 3'd1};
        logic [31:0] exps [10] = '{32'h0000007F, 32'h000080FF, 32'hFFFF80FF, 32'h00000080,
                                   32'hFFFFFF80, 32'h80FF7F01, 32'h00007F01, 32'hFFFF80FF,
                                   32'h80FF7F01, 32'h00000001};
        RegWrite_W = 1'b0; MemtoReg_W = 2'b01; ReadData_W = 32'h80FF7F01;
        for (int i = 0; i < 10; i++) begin
            ALUOut_W = {30'h0, offs[i]};
            ExtDM_W  = exts[i];
            #1;
            checks++;
            if (WD_W !== exps[i]) begin
                errors++;
                $display("FAIL load_ext[%0d] off=%0d ext=%0d got=%h exp=%h",
                         i, offs[i], exts[i], WD_W, exps[i]);
            end
        end
        MemtoReg_W = 2'b10; HL_W = 32'hCAFEF00D;
        #1;
        checks++;
        if (WD_W !== 32'hCAFEF00D) begin
            errors++; $display("FAIL sel_hl got=%h exp=cafef00d", WD_W);
        end
        MemtoReg_W = 2'b11; ALUOut_W = 32'h55AA0003;
        #1;
        checks++;
        if (WD_W !== 32'h55AA0003) begin
            errors++; $display("FAIL sel_alu11 got=%h exp=55aa0003", WD_W);
        end
        // Commit a sign-extended byte load into register 9
        MemtoReg_W = 2'b01; ExtDM_W = 3'b010; ALUOut_W = 32'h00000001;
        RegWrite_W = 1'b1; WriteReg_W = 5'd9;
        tick();
        RegWrite_W = 1'b0; A1 = 5'd9;
        #1;
        checks++;
        if (RD1 !== 32'h0000007F) begin
            errors++; $display("FAIL load_commit got=%h exp=0000007f", RD1);
        end
        checks++;
        if (WrCount !== 16'd2) begin
            errors++; $display("FAIL load_wrcount got=%0d exp=2", WrCount);
        end
    endtask

    task automatic test_jal();
        Jal_W = 1'b1; npc_W = 32'h00003004; WriteReg_W = 5'd31; MemtoReg_W = 2'b01;
        RegWrite_W = 1'b1;
        #1;
        checks++;
        if (WD_W !== 32'h00003008) begin
            errors++; $display("FAIL jal_wd got=%h exp=00003008", WD_W);
        end
        tick();
        RegWrite_W = 1'b0; A1 = 5'd31;
        #1;
        checks++;
        if (RD1 !== 32'h00003008) begin
            errors++; $display("FAIL jal_r31 got=%h exp=00003008", RD1);
        end
        checks++;
        if (WrCount !== 16'd3) begin
            errors++; $display("FAIL jal_wrcount got=%0d exp=3", WrCount);
        end
        npc_W = 32'hFFFFFFFC;
        #1;
        checks++;
        if (WD_W !== 32'h00000000) begin
            errors++; $display("FAIL jal_wrap got=%h exp=00000000", WD_W);
        end
        Jal_W = 1'b0; npc_W = '0;
    endtask

    task automatic test_reg0();
        RegWrite_W = 1'b1; WriteReg_W = 5'd0; MemtoReg_W = 2'b00; ALUOut_W = 32'hDEADBEEF;
        A1 = 5'd0;
        tick();
        RegWrite_W = 1'b0;
        #1;
        checks++;
        if (RD1 !== 32'h0) begin
            errors++; $display("FAIL reg0_rd1 got=%h exp=00000000", RD1);
        end
        checks++;
        if (WrCount !== 16'd3) begin
            errors++; $display("FAIL reg0_wrcount got=%0d exp=3", WrCount);
        end
    endtask

    task automatic test_no_write();
        RegWrite_W = 1'b0; WriteReg_W = 5'd5; MemtoReg_W = 2'b00; ALUOut_W = 32'hFFFFFFFF;
        A1 = 5'd5;
        tick(); tick();
        checks++;
        if (RD1 !== 32'h12345678) begin
            errors++; $display("FAIL nowrite_rd1 got=%h exp=12345678", RD1);
        end
        checks++;
        if (WrCount !== 16'd3) begin
            errors++; $display("FAIL nowrite_wrcount got=%0d exp=3", WrCount);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] exp_same;
        RegWrite_W = 1'b1; WriteReg_W = 5'd7; MemtoReg_W = 2'b00; ALUOut_W = 32'h11111111;
        tick();
        ALUOut_W = 32'hA5A5A5A5; A1 = 5'd7; A2 = 5'd7;
`ifdef WB_REGFILE_BYPASS_EN
        exp_same = 32'hA5A5A5A5;
`else
        exp_same = 32'h11111111;
`endif
        #1;
        checks++;
        if (RD2 !== exp_same) begin
            errors++; $display("FAIL bypass_same_rd2 got=%h exp=%h", RD2, exp_same);
        end
        checks++;
        if (RD1 !== exp_same) begin
            errors++; $display("FAIL bypass_same_rd1 got=%h exp=%h", RD1, exp_same);
        end
        tick();
        RegWrite_W = 1'b0;
        #1;
        checks++;
        if (RD2 !== 32'hA5A5A5A5) begin
            errors++; $display("FAIL bypass_next_rd2 got=%h exp=a5a5a5a5", RD2);
        end
        checks++;
        if (RD1 !== 32'hA5A5A5A5) begin
            errors++; $display("FAIL bypass_next_rd1 got=%h exp=a5a5a5a5", RD1);
        end
        checks++;
        if (WrCount !== 16'd5) begin
            errors++; $display("FAIL bypass_wrcount got=%0d exp=5", WrCount);
        end
    endtask

    task automatic test_reset_drop();
        RegWrite_W = 1'b1; WriteReg_W = 5'd12; MemtoReg_W = 2'b00; ALUOut_W = 32'h00000077;
        A1 = 5'd5; A2 = 5'd12;
        reset = 1'b1;
        #1;
        checks++;
        if (WrCount !== 16'd0) begin
            errors++; $display("FAIL rst_async_wrcount got=%0d exp=0", WrCount);
        end
        checks++;
        if (RD1 !== 32'h0) begin
            errors++; $display("FAIL rst_async_rd1 got=%h exp=00000000", RD1);
        end
        tick(); tick();
        checks++;
        if (RD2 !== 32'h0) begin
            errors++; $display("FAIL rst_held_drop got=%h exp=00000000", RD2);
        end
        reset = 1'b0;
        tick();
        RegWrite_W = 1'b0;
        #1;
        checks++;
        if (RD2 !== 32'h00000077) begin
            errors++; $display("FAIL rst_first_write got=%h exp=00000077", RD2);
        end
        checks++;
        if (WrCount !== 16'd1) begin
            errors++; $display("FAIL rst_first_wrcount got=%0d exp=1", WrCount);
        end
    endtask

    task automatic test_wrap();
        RegWrite_W = 1'b1; WriteReg_W = 5'd3; MemtoReg_W = 2'b00; ALUOut_W = 32'h00000033;
        for (int i = 0; i < 65534; i++) begin
            tick();
        end
        checks++;
        if (WrCount !== 16'hFFFF) begin
            errors++; $display("FAIL wrap_full got=%h exp=ffff", WrCount);
        end
        tick();
        RegWrite_W = 1'b0;
        checks++;
        if (WrCount !== 16'h0000) begin
            errors++; $display("FAIL wrap_zero got=%h exp=0000", WrCount);
        end
        A1 = 5'd3; A2 = 5'd12;
        #1;
        checks++;
        if (RD1 !== 32'h00000033) begin
            errors++; $display("FAIL wrap_r3 got=%h exp=00000033", RD1);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (RD1 !== 32'h0) begin
            errors++; $display("FAIL midrst_rd1 got=%h exp=00000000", RD1);
        end
        checks++;
        if (RD2 !== 32'h0) begin
            errors++; $display("FAIL midrst_rd2 got=%h exp=00000000", RD2);
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alu_write();
        test_load_ext();
        test_jal();
        test_reg0();
        test_no_write();
        test_bypass();
        test_reset_drop();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
